chain_control_stat_capture: RTL and testbench
=============================================

// Module: chain_control_stat_capture
// PURPOSE
//  Parametrised status-capture stage for the egress/ingress chain-control register map. Takes NUM_SLOT
//  ap_vld-qualified status inputs and holds each in a live register, in latch or accumulate mode.
//  A snapshot handshake copies all slots atomically into a shadow bank that drives the packed reg_in
//  bus read by the register block. Optional clear-on-snapshot resets accumulators.
// PARAMETERS
//  NUM_SLOT   16     number of status slots
//  DATA_W     48     payload width per slot; DATA_W <= SLOT_W-2
//  SLOT_W     64     bus stride per slot in reg_in
//  ACC_MASK   16'h0  bit i=1: slot i accumulates (saturating add); 0: latch last value
// PORTS
//  ap_clk     in   1                  clock
//  ap_rst_n   in   1                  asynchronous reset, active low
//  in_vld     in   NUM_SLOT           per-slot update strobe (ap_vld)
//  in_data    in   NUM_SLOT*DATA_W    slot i payload at [i*DATA_W +: DATA_W]
//  snap_req   in   1                  snapshot request
//  snap_clr   in   1                  qualifies snap_req: clear accumulators and sat flags
//  snap_ack   out  1                  one-cycle pulse; the shadow bank has been updated
//  snap_cnt   out  16                 number of snapshots taken, wraps 16'hFFFF->0
//  reg_in     out  NUM_SLOT*SLOT_W    packed shadow bank
// BEHAVIOUR
//  Reset: all live/shadow values, flags, snap_ack, snap_cnt and reg_in are 0. Reset is honoured
//   mid-operation, including during a pending ack.
//  Slot layout in reg_in[i*SLOT_W +: SLOT_W]:
//   [DATA_W-1:0] value; [DATA_W] updated; [DATA_W+1] saturated; all other bits 0.
//  Live update, one cycle after in_vld[i]=1:
//   - latch slot: live <= in_data.
//   - accumulate slot: live <= live + in_data. The sum is taken in DATA_W+1 bits.
//     On carry, live <= all-ones and sat <= 1.
//   - updated <= 1 on every vld.
//   - sat is sticky; it is always 0 for latch slots.
//  Snapshot trigger: the cycle where snap_req=1 and snap_ack=0 (the capture cycle). snap_req held
//   high therefore snapshots every other cycle.
//  At the capture edge:
//   - shadow <= live value and flags as they stood before the edge.
//   - snap_ack <= 1 for one cycle; reg_in changes on the same edge that raises snap_ack.
//   - snap_cnt <= snap_cnt+1.
//   - live updated <= 0.
//   - if snap_clr: accumulate-slot live <= 0 and sat <= 0. Latch-slot values are kept.
//  Simultaneous in_vld[i] and capture:
//   - shadow takes the old value.
//   - live updated ends at 1.
//   - latch slot: live <= in_data.
//   - accumulate slot with snap_clr: live <= in_data; sat from this add only (cannot carry from 0).
//   - accumulate slot without clr: live <= old+in_data with saturation.
//  snap_clr without snap_req is ignored. in_vld for slots >= NUM_SLOT does not exist.
//  Latency: in_vld -> live 1 cycle; snap_req -> reg_in/snap_ack 1 cycle. No back-pressure on in_vld.
// STRUCTURE
//  chain_control_stat_defs.vh holds:
//   - slot-layout offsets: VAL_LSB, UPD_BIT = DATA_W, SAT_BIT = DATA_W+1
//   - default widths
//   - the ACC_MASK bit meaning
//  Sub-module chain_control_stat_slot: one slot's live register, adder/saturation, flags and shadow.
//   Parameters DATA_W, SLOT_W, ACCUM. Instantiated NUM_SLOT times in a generate loop.
//  Top level holds only the capture control, snap_ack, snap_cnt and bus packing.
// TESTING
//  1 Reset then snapshot -> reg_in all 0, snap_ack one pulse, snap_cnt=1.
//  2 Latch slot 0: vld with 48'h123456789ABC, then snap_req
//    -> slot0 value=48'h123456789ABC, updated=1, sat=0.
//    A second snapshot with no vld -> same value, updated=0.
//  3 Accumulate slot 3 (ACC_MASK bit3): vld 5 then 7, snapshot -> value=12.
//    Snapshot with snap_clr, then vld 1, snapshot -> value=1.
//  4 Saturation: slot 3 live=48'hFFFF_FFFF_FFF0, vld 48'h20 -> value=48'hFFFF_FFFF_FFFF, sat=1.
//    Snapshot+clr clears it; the following snapshot shows sat=0, value=0.
//  5 Same-cycle vld and capture, accumulate slot, live=10, in_data=4, no clr
//    -> shadow=10, updated=1. Next snapshot -> value=14, updated=1.
//    Repeat with clr -> the next snapshot value=4.
//  6 snap_req held high 6 cycles -> 3 ack pulses, snap_cnt+=3.
//    Assert ap_rst_n=0 while snap_ack=1 -> ack and all outputs 0 immediately.
//    Also check snap_cnt 16'hFFFF -> 0 on the next snapshot.

Source files
------------

// File: rtl/chain_control_stat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chain_control_stat_pkg
//  Description : Shared constants and slot-layout helpers for the
//                chain-control status-capture stage.
//                Slot layout within one SLOT_W stride of reg_in:
//                  [DATA_W-1:0] value, [DATA_W] updated, [DATA_W+1] saturated,
//                  all remaining bits zero.
//                ACC_MASK bit i = 1 : slot i accumulates (saturating add)
//                ACC_MASK bit i = 0 : slot i latches the last value
//  Revision    : 1.0 - initial release
// ============================================================================
package chain_control_stat_pkg;

  localparam int DEF_NUM_SLOT = 16;
  localparam int DEF_DATA_W   = 48;
  localparam int DEF_SLOT_W   = 64;

  localparam int VAL_LSB = 0;

  function automatic int upd_bit(input int data_w);
    return data_w;
  endfunction

  function automatic int sat_bit(input int data_w);
    return data_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chain_control_stat_slot.sv
`default_nettype none
// ============================================================================
//  Module      : chain_control_stat_slot
//  Description : One status slot: live register (latch or saturating
//                accumulate), updated/saturated flags and the shadow copy
//                taken on a capture edge.
//  Ports       : ap_clk, ap_rst_n      clock, async active-low reset
//                in_vld, in_data       update strobe and payload
//                capture, clr          capture edge qualifier, clear on capture
//                slot_bus              packed shadow value + flags
//  Revision    : 1.0 - initial release
// ============================================================================
module chain_control_stat_slot
  import chain_control_stat_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter bit ACCUM  = 1'b0
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              capture,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot_bus
);

  localparam int UPD_BIT = upd_bit(DATA_W);
  localparam int SAT_BIT = sat_bit(DATA_W);

  logic [DATA_W-1:0] live_q, live_d;
  logic              upd_q, upd_d;
  logic              sat_q, sat_d;
  logic [DATA_W-1:0] shadow_val_q, shadow_val_d;
  logic              shadow_upd_q, shadow_upd_d;
  logic              shadow_sat_q, shadow_sat_d;
  logic [DATA_W-1:0] base;
  logic [DATA_W:0]   sum;

  always_comb begin
    base  = live_q;
    sat_d = sat_q;
    upd_d = upd_q;
    if (capture) begin
      upd_d = 1'b0;
      // Clear-on-capture zeroes the accumulator before a same-cycle add,
      // so that add starts from 0 and its carry alone decides sat.
      if (clr && ACCUM) begin
        base  = '0;
        sat_d = 1'b0;
      end
    end
    sum    = {1'b0, base} + {1'b0, in_data};
    live_d = base;
    if (in_vld) begin
      upd_d = 1'b1;
      if (ACCUM) begin
        if (sum[DATA_W]) begin
          live_d = '1;
          sat_d  = 1'b1;
        end else begin
          live_d = sum[DATA_W-1:0];
        end
      end else begin
        live_d = in_data;
      end
    end
    if (!ACCUM) begin
      sat_d = 1'b0;
    end
  end

  // Shadow takes the pre-edge live state.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_upd_d = shadow_upd_q;
    shadow_sat_d = shadow_sat_q;
    if (capture) begin
      shadow_val_d = live_q;
      shadow_upd_d = upd_q;
      shadow_sat_d = sat_q;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      live_q       <= '0;
      upd_q        <= 1'b0;
      sat_q        <= 1'b0;
      shadow_val_q <= '0;
      shadow_upd_q <= 1'b0;
      shadow_sat_q <= 1'b0;
    end else begin
      live_q       <= live_d;
      upd_q        <= upd_d;
      sat_q        <= sat_d;
      shadow_val_q <= shadow_val_d;
      shadow_upd_q <= shadow_upd_d;
      shadow_sat_q <= shadow_sat_d;
    end
  end

  always_comb begin
    slot_bus                        = '0;
    slot_bus[VAL_LSB +: DATA_W]     = shadow_val_q;
    slot_bus[UPD_BIT]               = shadow_upd_q;
    slot_bus[SAT_BIT]               = shadow_sat_q;
  end

endmodule
`default_nettype wire

// File: rtl/chain_control_stat_capture.sv
`default_nettype none
// ============================================================================
//  Module      : chain_control_stat_capture
//  Description : Status-capture stage for the chain-control register map.
//                NUM_SLOT ap_vld-qualified inputs are held in live registers
//                and copied atomically into a shadow bank on a snapshot
//                handshake; the shadow bank drives the packed reg_in bus.
//  Ports       : ap_clk, ap_rst_n      clock, async active-low reset
//                in_vld   [NUM_SLOT]   per-slot update strobe
//                in_data  [NUM_SLOT*DATA_W] slot payloads
//                snap_req, snap_clr    snapshot request, clear accumulators
//                snap_ack              one-cycle pulse, shadow bank updated
//                snap_cnt [16]         snapshot counter (wraps)
//                reg_in   [NUM_SLOT*SLOT_W] packed shadow bank
//  Revision    : 1.0 - initial release
// ============================================================================
module chain_control_stat_capture
  import chain_control_stat_pkg::*;
#(
  parameter int                  NUM_SLOT = DEF_NUM_SLOT,
  parameter int                  DATA_W   = DEF_DATA_W,
  parameter int                  SLOT_W   = DEF_SLOT_W,
  parameter logic [NUM_SLOT-1:0] ACC_MASK = '0
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_SLOT-1:0]        in_vld,
  input  logic [NUM_SLOT*DATA_W-1:0] in_data,
  input  logic                       snap_req,
  input  logic                       snap_clr,
  output logic                       snap_ack,
  output logic [15:0]                snap_cnt,
  output logic [NUM_SLOT*SLOT_W-1:0] reg_in
);

  logic        snap_ack_q, snap_ack_d;
  logic [15:0] snap_cnt_q, snap_cnt_d;
  logic        capture;

  // A request seen while the previous ack is still high is not a new
  // capture, so a held request snapshots every other cycle.
  always_comb begin
    capture    = snap_req & ~snap_ack_q;
    snap_ack_d = capture;
    snap_cnt_d = snap_cnt_q;
    if (capture) begin
      snap_cnt_d = snap_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      snap_ack_q <= 1'b0;
      snap_cnt_q <= '0;
    end else begin
      snap_ack_q <= snap_ack_d;
      snap_cnt_q <= snap_cnt_d;
    end
  end

  assign snap_ack = snap_ack_q;
  assign snap_cnt = snap_cnt_q;

  for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
    chain_control_stat_slot #(
      .DATA_W (DATA_W),
      .SLOT_W (SLOT_W),
      .ACCUM  (ACC_MASK[i])
    ) u_slot (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .in_vld   (in_vld[i]),
      .in_data  (in_data[i*DATA_W +: DATA_W]),
      .capture  (capture),
      .clr      (snap_clr),
      .slot_bus (reg_in[i*SLOT_W +: SLOT_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_chain_control_stat_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chain_control_stat_capture
//  Description : Self-checking bench for chain_control_stat_capture with a
//                behavioural per-slot model (plain arithmetic on arrays).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chain_control_stat_capture;

  localparam int          NS   = 16;
  localparam int          DW   = 48;
  localparam int          SW   = 64;
  localparam logic [15:0] MASK = 16'h00F8;   // slots 3..7 accumulate
  localparam longint unsigned MAXV = (64'd1 << DW) - 64'd1;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic [NS-1:0]       in_vld = '0;
  logic [NS*DW-1:0]    in_data = '0;
  logic                snap_req = 1'b0;
  logic                snap_clr = 1'b0;
  logic                snap_ack;
  logic [15:0]         snap_cnt;
  logic [NS*SW-1:0]    reg_in;

  chain_control_stat_capture #(
    .NUM_SLOT (NS), .DATA_W (DW), .SLOT_W (SW), .ACC_MASK (MASK)
  ) dut (
    .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .in_vld (in_vld), .in_data (in_data),
    .snap_req (snap_req), .snap_clr (snap_clr), .snap_ack (snap_ack),
    .snap_cnt (snap_cnt), .reg_in (reg_in)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  longint unsigned live [NS];
  bit              upd  [NS];
  bit              sat  [NS];
  longint unsigned sh_v [NS];
  bit              sh_u [NS];
  bit              sh_s [NS];
  bit              m_ack;
  int unsigned     m_cnt;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      live[i] = 0; upd[i] = 0; sat[i] = 0;
      sh_v[i] = 0; sh_u[i] = 0; sh_s[i] = 0;
    end
    m_ack = 0;
    m_cnt = 0;
  endtask

  function automatic logic [NS*SW-1:0] exp_bus();
    logic [NS*SW-1:0] b;
    logic [SW-1:0]    s;
    b = '0;
    for (int i = 0; i < NS; i++) begin
      s = '0;
      s[DW-1:0] = sh_v[i][DW-1:0];
      s[DW]     = sh_u[i];
      s[DW+1]   = sh_s[i];
      b[i*SW +: SW] = s;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag);
    logic [NS*SW-1:0] e;
    e = exp_bus();
    checks++;
    assert (reg_in === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, reg_in, e);
    end
  endtask

  function automatic logic [63:0] slot_field(input int s);
    return reg_in[s*SW +: SW];
  endfunction

  function automatic logic [63:0] mk_field(input longint unsigned v, input bit u, input bit st);
    logic [63:0] f;
    f = '0;
    f[DW-1:0] = v[DW-1:0];
    f[DW]     = u;
    f[DW+1]   = st;
    return f;
  endfunction

  // One clock: advance the model from the current inputs, then compare.
  task automatic step(input string tag);
    bit cap;
    longint unsigned d, sum;
    cap = snap_req && !m_ack;
    if (cap) begin
      for (int i = 0; i < NS; i++) begin
        sh_v[i] = live[i]; sh_u[i] = upd[i]; sh_s[i] = sat[i];
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (cap) begin
        upd[i] = 0;
        if (snap_clr && MASK[i]) begin live[i] = 0; sat[i] = 0; end
      end
      if (in_vld[i]) begin
        d = 64'(in_data[i*DW +: DW]);
        upd[i] = 1;
        if (MASK[i]) begin
          sum = live[i] + d;
          if (sum > MAXV) begin live[i] = MAXV; sat[i] = 1; end
          else live[i] = sum;
        end else begin
          live[i] = d;
        end
      end
    end
    m_ack = cap;
    if (cap) m_cnt = (m_cnt + 1) % 65536;
    @(posedge ap_clk);
    #1;
    chk_bus({tag, "_bus"});
    chk({tag, "_ack"}, 64'(snap_ack), 64'(m_ack));
    chk({tag, "_cnt"}, 64'(snap_cnt), 64'(m_cnt));
  endtask

  task automatic drive(input string tag, input int slot, input logic [DW-1:0] v,
                       input bit req, input bit clr);
    in_vld = '0;
    in_data = '0;
    if (slot >= 0) begin
      in_vld[slot] = 1'b1;
      in_data[slot*DW +: DW] = v;
    end
    snap_req = req;
    snap_clr = clr;
    step(tag);
    in_vld = '0;
    snap_req = 1'b0;
    snap_clr = 1'b0;
  endtask

  initial begin : main
    int pulses;
    int unsigned cnt0;
    model_reset();
    // ---- 1: reset, first snapshot
    repeat (3) @(posedge ap_clk);
    #1;
    chk_bus("rst_bus");
    chk("rst_ack", 64'(snap_ack), 64'd0);
    chk("rst_cnt", 64'(snap_cnt), 64'd0);
    ap_rst_n = 1'b1;
    drive("t1_snap", -1, '0, 1, 0);
    chk("t1_ack_hi", 64'(snap_ack), 64'd1);
    chk("t1_cnt1", 64'(snap_cnt), 64'd1);
    drive("t1_idle", -1, '0, 0, 0);
    chk("t1_ack_lo", 64'(snap_ack), 64'd0);

    // ---- 2: latch slot 0
    drive("t2_vld", 0, 48'h123456789ABC, 0, 0);
    drive("t2_snap", -1, '0, 1, 0);
    chk("t2_slot0", slot_field(0), mk_field(64'h123456789ABC, 1, 0));
    drive("t2_idle", -1, '0, 0, 0);
    drive("t2_snap2", -1, '0, 1, 0);
    chk("t2_slot0_b", slot_field(0), mk_field(64'h123456789ABC, 0, 0));
    drive("t2_idle2", -1, '0, 0, 0);

    // ---- 3: accumulate slot 3
    drive("t3_v5", 3, 48'd5, 0, 0);
    drive("t3_v7", 3, 48'd7, 0, 0);
    drive("t3_snap", -1, '0, 1, 0);
    chk("t3_sum12", slot_field(3), mk_field(64'd12, 1, 0));
    drive("t3_idle", -1, '0, 0, 0);
    drive("t3_clr", -1, '0, 1, 1);
    drive("t3_idle2", -1, '0, 0, 0);
    drive("t3_v1", 3, 48'd1, 0, 0);
    drive("t3_snap2", -1, '0, 1, 0);
    chk("t3_val1", slot_field(3), mk_field(64'd1, 1, 0));
    drive("t3_idle3", -1, '0, 0, 0);

    // ---- 4: saturation
    drive("t4_clr", -1, '0, 1, 1);
    drive("t4_idle", -1, '0, 0, 0);
    drive("t4_big", 3, 48'hFFFF_FFFF_FFF0, 0, 0);
    drive("t4_v20", 3, 48'h20, 0, 0);
    drive("t4_snap", -1, '0, 1, 0);
    chk("t4_sat", slot_field(3), mk_field(MAXV, 1, 1));
    drive("t4_idle2", -1, '0, 0, 0);
    drive("t4_clr2", -1, '0, 1, 1);
    drive("t4_idle3", -1, '0, 0, 0);
    drive("t4_snap2", -1, '0, 1, 0);
    chk("t4_cleared", slot_field(3), mk_field(64'd0, 0, 0));
    drive("t4_idle4", -1, '0, 0, 0);

    // ---- 5: same-cycle vld and capture
    drive("t5_v10", 3, 48'd10, 0, 0);
    drive("t5_idle", -1, '0, 0, 0);
    drive("t5_both", 3, 48'd4, 1, 0);
    chk("t5_shadow10", slot_field(3), mk_field(64'd10, 1, 0));
    drive("t5_idle2", -1, '0, 0, 0);
    drive("t5_snap", -1, '0, 1, 0);
    chk("t5_val14", slot_field(3), mk_field(64'd14, 1, 0));
    drive("t5_idle3", -1, '0, 0, 0);
    drive("t5_both_clr", 3, 48'd4, 1, 1);
    chk("t5_shadow14", slot_field(3), mk_field(64'd14, 0, 0));
    drive("t5_idle4", -1, '0, 0, 0);
    drive("t5_snap2", -1, '0, 1, 0);
    chk("t5_val4", slot_field(3), mk_field(64'd4, 1, 0));
    drive("t5_idle5", -1, '0, 0, 0);
    // snap_clr alone must not clear
    drive("t5_clr_only", -1, '0, 0, 1);
    drive("t5_snap3", -1, '0, 1, 0);
    chk("t5_val4_kept", slot_field(3), mk_field(64'd4, 0, 0));
    drive("t5_idle6", -1, '0, 0, 0);

    // ---- 6: held request, reset during ack, counter wrap
    pulses = 0;
    cnt0 = m_cnt;
    snap_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step("t6_held");
      if (snap_ack === 1'b1) pulses++;
    end
    snap_req = 1'b0;
    chk("t6_pulses", 64'(pulses), 64'd3);
    chk("t6_cnt_plus3", 64'(snap_cnt), 64'((cnt0 + 3) % 65536));
    drive("t6_v", 0, 48'hABCD, 0, 0);
    drive("t6_snap", -1, '0, 1, 0);
    chk("t6_ack_before_rst", 64'(snap_ack), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_ack", 64'(snap_ack), 64'd0);
    chk("t6_rst_cnt", 64'(snap_cnt), 64'd0);
    chk_bus("t6_rst_bus");
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    drive("t6_post_rst", -1, '0, 0, 0);

    force dut.snap_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    drive("t6_preset", -1, '0, 0, 0);
    release dut.snap_cnt_q;
    drive("t6_hold", -1, '0, 0, 0);
    chk("t6_cnt_ffff", 64'(snap_cnt), 64'hFFFF);
    drive("t6_wrap", -1, '0, 1, 0);
    chk("t6_cnt_wrap", 64'(snap_cnt), 64'd0);
    drive("t6_idle", -1, '0, 0, 0);

    // ---- random traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_vld = NS'($urandom & $urandom);
      for (int i = 0; i < NS; i++) begin
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: in_data[i*DW +: DW] = DW'($urandom_range(0, 255));
          1: in_data[i*DW +: DW] = {16'hFFFF, r[31:0]};
          default: in_data[i*DW +: DW] = r[DW-1:0];
        endcase
      end
      snap_req = ($urandom_range(0, 2) == 0);
      snap_clr = ($urandom_range(0, 1) == 0);
      step("rnd");
    end
    in_vld = '0;
    snap_req = 1'b0;
    snap_clr = 1'b0;
    step("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
